// File: rtl/l2_request_arbiter_if.sv
// Request/return bus between NUM_PORTS requesters, the L2 arbiter and memory.
// The arbiter takes the slave modport; the requester/memory side takes master.
interface l2_request_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int SUB_ID_W  = 2,
    parameter int ADDR_W    = 30
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int ID_W   = PORT_W + SUB_ID_W;

    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS-1:0]          req_rnw;
    logic [NUM_PORTS*5-1:0]        req_burst;
    logic [NUM_PORTS*SUB_ID_W-1:0] req_sub_id;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rnw;
    logic [4:0]        mem_burst;
    logic [ID_W-1:0]   mem_id;

    logic            ret_valid;
    logic [ID_W-1:0] ret_id;
    logic [31:0]     ret_data;

    logic [NUM_PORTS-1:0] rd_valid;
    logic [SUB_ID_W-1:0]  rd_sub_id;
    logic [31:0]          rd_data;

    modport slave (
        input  req_valid, req_addr, req_rnw, req_burst, req_sub_id,
        output req_ready,
        output mem_valid, mem_addr, mem_rnw, mem_burst, mem_id,
        input  mem_ready,
        input  ret_valid, ret_id, ret_data,
        output rd_valid, rd_sub_id, rd_data
    );

    modport master (
        output req_valid, req_addr, req_rnw, req_burst, req_sub_id,
        input  req_ready,
        input  mem_valid, mem_addr, mem_rnw, mem_burst, mem_id,
        output mem_ready,
        output ret_valid, ret_id, ret_data,
        input  rd_valid, rd_sub_id, rd_data
    );
endinterface

// File: rtl/l2_request_arbiter.sv
// Per-port request FIFOs, round-robin arbiter and registered read return path.
// Define L2_ARB_FIXED_PRIORITY_EN to select lowest-index fixed priority.
module l2_request_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int SUB_ID_W   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 30
) (
    input logic clk,
    input logic rst_n,
    l2_request_arbiter_if.slave bus
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int ID_W   = PORT_W + SUB_ID_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                rnw;
        logic [4:0]          burst;
        logic [SUB_ID_W-1:0] sub_id;
    } entry_t;

    entry_t [NUM_PORTS-1:0] head;
    logic   [NUM_PORTS-1:0] full;
    logic   [NUM_PORTS-1:0] nonempty;
    logic   [NUM_PORTS-1:0] push;
    logic   [NUM_PORTS-1:0] pop;
    logic   [PORT_W-1:0]    grant;
    logic                   any_req;
    logic                   load;

    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rnw_q;
    logic [4:0]        mem_burst_q;
    logic [ID_W-1:0]   mem_id_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        entry_t           store [FIFO_DEPTH];
        entry_t           push_ent;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;

        assign push_ent = '{
            addr:   bus.req_addr[p*ADDR_W +: ADDR_W],
            rnw:    bus.req_rnw[p],
            burst:  bus.req_burst[p*5 +: 5],
            sub_id: bus.req_sub_id[p*SUB_ID_W +: SUB_ID_W]
        };

        // ready comes only from registered occupancy: a full FIFO
        // never accepts, even on the edge where it also pops
        assign full[p]     = (count == CNT_W'(FIFO_DEPTH));
        assign nonempty[p] = (count != '0);
        assign push[p]     = bus.req_valid[p] && !full[p];
        assign pop[p]      = load && (grant == PORT_W'(p));
        assign head[p]     = store[rd_ptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[p])  rd_ptr <= rd_ptr + PTR_W'(1);
                unique case ({push[p], pop[p]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push[p]) store[wr_ptr] <= push_ent;
        end
    end

    assign bus.req_ready = ~full;
    assign any_req       = |nonempty;
    assign load          = (!mem_valid_q || bus.mem_ready) && any_req;

`ifdef L2_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (nonempty[i]) grant = PORT_W'(i);
        end
    end
`else
    logic [PORT_W-1:0] last_grant;

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_PORTS;
            if (!found && nonempty[idx]) begin
                grant = PORT_W'(idx);
                found = 1'b1;
            end
        end
    end

    // reset to the top port so the search starts at port 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_W'(NUM_PORTS - 1);
        end else if (load) begin
            last_grant <= grant;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_rnw_q   <= 1'b0;
            mem_burst_q <= '0;
            mem_id_q    <= '0;
        end else if (load) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= head[grant].addr;
            mem_rnw_q   <= head[grant].rnw;
            mem_burst_q <= head[grant].burst;
            mem_id_q    <= {grant, head[grant].sub_id};
        end else if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rnw   = mem_rnw_q;
    assign bus.mem_burst = mem_burst_q;
    assign bus.mem_id    = mem_id_q;

    logic [PORT_W-1:0]    ret_port;
    logic [NUM_PORTS-1:0] rd_valid_q;
    logic [SUB_ID_W-1:0]  rd_sub_id_q;
    logic [31:0]          rd_data_q;

    assign ret_port = bus.ret_id[ID_W-1 -: PORT_W];

    // returns to a port index that does not exist are silently dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q  <= '0;
            rd_sub_id_q <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_valid_q <= '0;
            if (bus.ret_valid) begin
                if (int'(ret_port) < NUM_PORTS) begin
                    rd_valid_q <= NUM_PORTS'(1) << ret_port;
                end
                rd_sub_id_q <= bus.ret_id[SUB_ID_W-1:0];
                rd_data_q   <= bus.ret_data;
            end
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_sub_id = rd_sub_id_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboard bench for l2_request_arbiter (2-port main instance,
// 3-port instance for dropped-return checks).
module tb_l2_request_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_request_arbiter_if #(.NUM_PORTS(2), .SUB_ID_W(2), .ADDR_W(30)) bus ();
    l2_request_arbiter_if #(.NUM_PORTS(3), .SUB_ID_W(2), .ADDR_W(30)) bus3 ();

    l2_request_arbiter #(
        .NUM_PORTS(2), .SUB_ID_W(2), .FIFO_DEPTH(16), .ADDR_W(30)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    l2_request_arbiter #(
        .NUM_PORTS(3), .SUB_ID_W(2), .FIFO_DEPTH(16), .ADDR_W(30)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    typedef struct packed {
        logic [29:0] addr;
        logic        rnw;
        logic [4:0]  burst;
        logic [2:0]  id;
    } mreq_t;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  sid;
        logic [31:0] data;
    } rret_t;

    mreq_t mq[$];
    rret_t rq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int p, input logic [29:0] a,
                           input logic rnw, input logic [4:0] b,
                           input logic [1:0] s);
        bus.req_valid[p]         = 1'b1;
        bus.req_addr[p*30 +: 30] = a;
        bus.req_rnw[p]           = rnw;
        bus.req_burst[p*5 +: 5]  = b;
        bus.req_sub_id[p*2 +: 2] = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // monitor: compares every memory handshake and read return
    initial begin
        mreq_t e;
        rret_t r;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_valid && bus.mem_ready) begin
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected: got addr %0h id %0h, expected none",
                             bus.mem_addr, bus.mem_id);
                end else begin
                    e = mq.pop_front();
                    chk("mem_req", {bus.mem_addr, bus.mem_rnw,
                                    bus.mem_burst, bus.mem_id}, e);
                end
            end
            if (bus.rd_valid != '0) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got rd_valid %0b, expected none",
                             bus.rd_valid);
                end else begin
                    r = rq.pop_front();
                    chk("rd_ret", {bus.rd_valid, bus.rd_sub_id, bus.rd_data}, r);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cyc;
        logic rdy;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_rnw = '0;
        bus.req_burst = '0;
        bus.req_sub_id = '0;
        bus.mem_ready = 1'b1;
        bus.ret_valid = 1'b0;
        bus.ret_id = '0;
        bus.ret_data = '0;
        bus3.req_valid = '0;
        bus3.req_addr = '0;
        bus3.req_rnw = '0;
        bus3.req_burst = '0;
        bus3.req_sub_id = '0;
        bus3.mem_ready = 1'b1;
        bus3.ret_valid = 1'b0;
        bus3.ret_id = '0;
        bus3.ret_data = '0;

        #1;
        chk("rst_req_ready", bus.req_ready, 2'b11);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_mem_id", bus.mem_id, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single read on port 0
        mq.push_back('{30'h100, 1'b1, 5'd3, 3'b001});
        set_req(0, 30'h100, 1'b1, 5'd3, 2'd1);
        tick();
        idle();
        chk("lat_after_push", bus.mem_valid, 0);
        tick();
        chk("lat_valid", bus.mem_valid, 1);
        chk("lat_addr", bus.mem_addr, 30'h100);
        chk("lat_id", bus.mem_id, 3'b001);
        tick();
        chk("drain_low", bus.mem_valid, 0);

        // two ports with three requests each
        do_reset();
`ifdef L2_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 3; i++)
            mq.push_back('{30'(32'h300 + i), 1'b1, 5'(i), {1'b0, 2'(i)}});
        for (int i = 0; i < 3; i++)
            mq.push_back('{30'(32'h400 + i), 1'b0, 5'(8 + i), {1'b1, 2'(i)}});
`else
        for (int i = 0; i < 3; i++) begin
            mq.push_back('{30'(32'h300 + i), 1'b1, 5'(i), {1'b0, 2'(i)}});
            mq.push_back('{30'(32'h400 + i), 1'b0, 5'(8 + i), {1'b1, 2'(i)}});
        end
`endif
        for (int i = 0; i < 3; i++) begin
            set_req(0, 30'(32'h300 + i), 1'b1, 5'(i), 2'(i));
            set_req(1, 30'(32'h400 + i), 1'b0, 5'(8 + i), 2'(i));
            tick();
        end
        idle();
        repeat (8) tick();
        chk("arb_drained", mq.size(), 0);

        // fill port 1 while memory stalls
        bus.mem_ready = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 17 && cyc < 40) begin
            set_req(1, 30'(32'h500 + n), 1'b1, 5'(n), 2'(n));
            rdy = bus.req_ready[1];
            tick();
            cyc++;
            if (rdy) begin
                mq.push_back('{30'(32'h500 + n), 1'b1, 5'(n), {1'b1, 2'(n)}});
                n++;
            end
        end
        idle();
        chk("full_accept_count", n, 17);
        chk("full_ready1", bus.req_ready[1], 0);
        chk("full_ready0", bus.req_ready[0], 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_hold", {bus.mem_valid, bus.mem_addr, bus.mem_rnw,
                               bus.mem_burst, bus.mem_id},
                {1'b1, 30'h500, 1'b1, 5'd0, 3'b100});
        end
        chk("stall_ready1", bus.req_ready[1], 0);
        bus.mem_ready = 1'b1;
        repeat (22) tick();
        chk("stall_drained", mq.size(), 0);

        // returns, with a concurrent request
        rq.push_back('{2'b10, 2'd2, 32'hDEADBEEF});
        mq.push_back('{30'h600, 1'b0, 5'd1, 3'b010});
        bus.ret_valid = 1'b1;
        bus.ret_id = 3'b110;
        bus.ret_data = 32'hDEADBEEF;
        set_req(0, 30'h600, 1'b0, 5'd1, 2'd2);
        tick();
        idle();
        rq.push_back('{2'b01, 2'd3, 32'h12345678});
        bus.ret_id = 3'b011;
        bus.ret_data = 32'h12345678;
        tick();
        bus.ret_valid = 1'b0;
        tick();
        chk("rd_one_cycle", bus.rd_valid, 0);

        bus3.ret_valid = 1'b1;
        bus3.ret_id = 4'b1101;
        bus3.ret_data = 32'hCAFE0001;
        tick();
        bus3.ret_valid = 1'b0;
        chk("drop_port3", bus3.rd_valid, 0);
        bus3.ret_valid = 1'b1;
        bus3.ret_id = 4'b1001;
        bus3.ret_data = 32'hCAFE0002;
        tick();
        bus3.ret_valid = 1'b0;
        chk("p3_port2_valid", bus3.rd_valid, 3'b100);
        chk("p3_port2_data", {bus3.rd_sub_id, bus3.rd_data}, {2'd1, 32'hCAFE0002});
        repeat (3) tick();

        // reset in the middle of traffic
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 30'(32'h700 + i), 1'b1, 5'd2, 2'(i));
            set_req(1, 30'(32'h780 + i), 1'b1, 5'd4, 2'(i));
            tick();
        end
        idle();
        chk("pre_rst_valid", bus.mem_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.mem_valid, 0);
        chk("mid_rst_ready", bus.req_ready, 2'b11);
        chk("mid_rst_fields", {bus.mem_addr, bus.mem_rnw, bus.mem_burst,
                               bus.mem_id}, 0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        mq.push_back('{30'h800, 1'b1, 5'd0, 3'b000});
        mq.push_back('{30'h880, 1'b0, 5'd7, 3'b111});
        set_req(0, 30'h800, 1'b1, 5'd0, 2'd0);
        set_req(1, 30'h880, 1'b0, 5'd7, 2'd3);
        tick();
        idle();
        chk("post_rst_lat", bus.mem_valid, 0);
        tick();
        chk("post_rst_first", {bus.mem_valid, bus.mem_id}, {1'b1, 3'b000});
        repeat (5) tick();

        chk("mq_empty", mq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/l2_request_arbiter.md
L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesting ports; legal range 2..8.
REQ-002 SHALL have parameter SUB_ID_W, default 2: per-port transaction sub-ID width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: per-port request FIFO depth; power of two, at least 2.
REQ-004 SHALL have parameter ADDR_W, default 30: word-address width.
REQ-005 SHALL derive ID_W = clog2(NUM_PORTS) + SUB_ID_W; mem_id is {port index, sub_id}.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, NUM_PORTS bits: per-port request valid.
REQ-009 SHALL have port req_ready, output, NUM_PORTS bits: per-port FIFO not full.
REQ-010 SHALL have port req_addr, input, NUM_PORTS*ADDR_W bits: per-port address.
REQ-011 SHALL have port req_rnw, input, NUM_PORTS bits: 1 = read.
REQ-012 SHALL have port req_burst, input, NUM_PORTS*5 bits: burst length minus 1.
REQ-013 SHALL have port req_sub_id, input, NUM_PORTS*SUB_ID_W bits: per-port sub-ID.
REQ-014 SHALL have port mem_valid, output, 1 bit: arbitrated request valid.
REQ-015 SHALL have port mem_ready, input, 1 bit: downstream accepts.
REQ-016 SHALL have ports mem_addr (ADDR_W), mem_rnw (1), mem_burst (5) and mem_id (ID_W), all outputs: the granted request.
REQ-017 SHALL have ports ret_valid (1), ret_id (ID_W) and ret_data (32), all inputs: read return from memory.
REQ-018 SHALL have port rd_valid, output, NUM_PORTS bits: one-hot per-port read return.
REQ-019 SHALL have ports rd_sub_id (SUB_ID_W) and rd_data (32), outputs shared by all ports.

Function
REQ-020 SHALL push port p's request into FIFO p on every edge where req_valid[p] && req_ready[p]; FIFO order is preserved per port.
REQ-021 SHALL drive req_ready[p] = !full from the registered occupancy, with no bypass; a full FIFO rejects a push even in a cycle where it pops.
REQ-022 SHALL load the output register when (!mem_valid || mem_ready) and at least one FIFO is non-empty, popping the granted FIFO on the same edge.
REQ-023 SHALL give a latency from a push on edge k (all FIFOs previously empty, output idle) to mem_valid high of exactly the cycle after edge k+1.
REQ-024 SHALL sustain one request per cycle while mem_ready is held high.
REQ-025 SHALL hold mem_* stable while mem_valid && !mem_ready; no FIFO pops in that state.
REQ-026 SHALL arbitrate round-robin by default: search starts at port (last_grant+1) mod NUM_PORTS; last_grant updates only on a load.
REQ-027 SHALL, after the final beat drains, deassert mem_valid on the edge where mem_ready is seen and no FIFO is non-empty.
REQ-028 SHALL register the return path: when ret_valid is high on edge k, rd_valid[ret_id port field] is high for exactly the cycle after edge k, with rd_sub_id and rd_data captured from the same edge.
REQ-029 SHALL apply no backpressure on the return path.
REQ-030 SHALL drop a return whose port field is >= NUM_PORTS: no rd_valid asserted.
REQ-031 SHALL keep request and return paths independent; simultaneous activity on both does not stall either.

Reset
REQ-032 SHALL, while rst_n is low, asynchronously empty all FIFOs and drive req_ready all ones, mem_valid 0, mem_addr/mem_rnw/mem_burst/mem_id 0, rd_valid 0, rd_sub_id/rd_data 0, and last_grant = NUM_PORTS-1 so that port 0 wins first.
REQ-033 SHALL discard in-flight requests on reset mid-operation; the first load after deassertion follows REQ-023.

Configuration
REQ-034 SHALL, when macro L2_ARB_FIXED_PRIORITY_EN is defined, use fixed priority with the lowest non-empty port index winning and last_grant unused; when it is undefined, SHALL use round-robin per REQ-026.

Verification
REQ-035 Bench SHALL cover: one read on port 0 (addr 0x100, sub_id 1), mem_ready=1 -> mem_valid high in the cycle after the second edge; mem_id=0b001; mem_addr=0x100.
REQ-036 Bench SHALL cover: ports 0 and 1 each hold 3 requests, mem_ready=1 -> grant order 0,1,0,1,0,1 (default build); with L2_ARB_FIXED_PRIORITY_EN -> order 0,0,0,1,1,1.
REQ-037 Bench SHALL cover: mem_ready=0 with 16 pushes to port 1 -> req_ready[1]=0 after the 16th accepted push plus the one held in the output register; mem_* unchanged across 10 stall cycles.
REQ-038 Bench SHALL cover: ret_valid with ret_id=0b110 and ret_data=0xDEADBEEF -> next cycle rd_valid=0b10, rd_sub_id=2, rd_data=0xDEADBEEF; with NUM_PORTS=3 and ret_id port field 3 -> rd_valid=0.
REQ-039 Bench SHALL cover: rst_n asserted low while mem_valid=1 and FIFOs hold data -> outputs take reset values immediately; after release, port 0 is granted first.
